// File: rtl/tag_nios_system_sysid_checker_if.sv
// Avalon-MM read-only bus between the sysid checker (master) and the
// system ID peripheral (slave).
interface tag_nios_system_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );
endinterface

// File: rtl/tag_nios_system_sysid_checker.sv
// Reads the system ID and timestamp words over Avalon-MM, compares them with
// the build-time expected values and reports sticky pass/fail/timeout flags.
module tag_nios_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1617931578,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail_id,
  output logic        fail_ts,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  tag_nios_system_sysid_checker_if.master avm
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    ID_REQ,
    ID_WAIT,
    TS_REQ,
    TS_WAIT,
    FINISH
  } state_t;

  state_t      state, state_d;
  logic [15:0] wait_cnt, wait_cnt_d;
  logic        pass_d, fail_id_d, fail_ts_d, timeout_d;
  logic [31:0] id_value_d, ts_value_d;
  logic        read_en, read_addr;
  logic        limit_hit;

  // NOTE: every signal written here gets a default before the case so that
  // no path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    pass_d     = pass;
    fail_id_d  = fail_id;
    fail_ts_d  = fail_ts;
    timeout_d  = timeout;
    id_value_d = id_value;
    ts_value_d = ts_value;
    read_en    = 1'b0;
    read_addr  = 1'b0;
    limit_hit  = (wait_cnt == TIMEOUT_LIMIT);

    unique case (state)
      IDLE: begin
        if (start) begin
          pass_d    = 1'b0;
          fail_id_d = 1'b0;
          fail_ts_d = 1'b0;
          timeout_d = 1'b0;
          state_d   = ID_REQ;
        end
      end

      // The read is withdrawn in the cycle the limit is reached, so a stalled
      // slave never sees a request that the FSM has already given up on.
      ID_REQ: begin
        read_en = !limit_hit;
        if (limit_hit) begin
          timeout_d = 1'b1;
          state_d   = FINISH;
        end else if (!avm.avm_waitrequest) begin
          if (avm.avm_readdatavalid) begin
            id_value_d = avm.avm_readdata;
            fail_id_d  = (avm.avm_readdata != EXPECTED_ID);
            state_d    = TS_REQ;
          end else begin
            state_d = ID_WAIT;
          end
        end
      end

      ID_WAIT: begin
        if (avm.avm_readdatavalid) begin
          id_value_d = avm.avm_readdata;
          fail_id_d  = (avm.avm_readdata != EXPECTED_ID);
          state_d    = TS_REQ;
        end else if (limit_hit) begin
          timeout_d = 1'b1;
          state_d   = FINISH;
        end
      end

      TS_REQ: begin
        read_en   = !limit_hit;
        read_addr = 1'b1;
        if (limit_hit) begin
          timeout_d = 1'b1;
          state_d   = FINISH;
        end else if (!avm.avm_waitrequest) begin
          if (avm.avm_readdatavalid) begin
            ts_value_d = avm.avm_readdata;
            fail_ts_d  = (avm.avm_readdata != EXPECTED_TS);
            state_d    = FINISH;
          end else begin
            state_d = TS_WAIT;
          end
        end
      end

      TS_WAIT: begin
        if (avm.avm_readdatavalid) begin
          ts_value_d = avm.avm_readdata;
          fail_ts_d  = (avm.avm_readdata != EXPECTED_TS);
          state_d    = FINISH;
        end else if (limit_hit) begin
          timeout_d = 1'b1;
          state_d   = FINISH;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Wait counter restarts on entry to each request and runs through its wait.
    if ((state_d == ID_REQ && state != ID_REQ) ||
        (state_d == TS_REQ && state != TS_REQ)) begin
      wait_cnt_d = 16'd0;
    end else if (state inside {ID_REQ, ID_WAIT, TS_REQ, TS_WAIT}) begin
      wait_cnt_d = wait_cnt + 16'd1;
    end

    // The verdict is registered on entry to FINISH so it is valid with done.
    if (state_d == FINISH && state != FINISH) begin
      pass_d = !(fail_id_d || fail_ts_d || timeout_d);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 16'd0;
      pass     <= 1'b0;
      fail_id  <= 1'b0;
      fail_ts  <= 1'b0;
      timeout  <= 1'b0;
      id_value <= 32'd0;
      ts_value <= 32'd0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
      pass     <= pass_d;
      fail_id  <= fail_id_d;
      fail_ts  <= fail_ts_d;
      timeout  <= timeout_d;
      id_value <= id_value_d;
      ts_value <= ts_value_d;
    end
  end

  assign busy            = (state != IDLE);
  assign done            = (state == FINISH);
  assign avm.avm_read    = read_en;
  assign avm.avm_address = read_addr;

endmodule

// File: doc/tag_nios_system_sysid_checker.md
TAG_NIOS_SYSTEM_SYSID_CHECKER -- requirements
Module: tag_nios_system_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'd0: value the ID word (address 0) SHALL match.
REQ-002 Parameter EXPECTED_TS, default 32'd1617931578: value the timestamp word (address 1) SHALL match.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 1..65535: per-read wait limit in clock cycles.
REQ-004 Clocking and reset SHALL be one clock and a synchronous, active-high reset.
REQ-005 clock  input  1  sole clock; all state SHALL update on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse that begins a check sequence.
REQ-008 busy  output  1  high while a sequence is in progress.
REQ-009 done  output  1  one-cycle pulse when a sequence ends.
REQ-010 pass  output  1  sticky result: both words matched.
REQ-011 fail_id  output  1  sticky result: ID word mismatched.
REQ-012 fail_ts  output  1  sticky result: timestamp word mismatched.
REQ-013 timeout  output  1  sticky result: a read exceeded TIMEOUT_CYCLES.
REQ-014 id_value  output  32  captured ID word.
REQ-015 ts_value  output  32  captured timestamp word.
REQ-016 avm_address  output  1  Avalon-MM word address (0 = ID, 1 = timestamp).
REQ-017 avm_read  output  1  Avalon-MM read strobe.
REQ-018 avm_waitrequest  input  1  slave stall; tie low for zero-wait slaves.
REQ-019 avm_readdata  input  32  read data.
REQ-020 avm_readdatavalid  input  1  read data qualifier.

Function
REQ-021 The FSM SHALL have states IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT and FINISH.
REQ-022 In IDLE, start=1 SHALL clear pass/fail_id/fail_ts/timeout and move to ID_REQ next cycle; start in any other state SHALL be ignored.
REQ-023 ID_REQ: avm_read=1 and avm_address=0, held until a cycle with avm_waitrequest=0, then go to ID_WAIT.
REQ-024 ID_WAIT: avm_read=0; on avm_readdatavalid=1 capture avm_readdata into id_value, set fail_id if it is not EXPECTED_ID, and go to TS_REQ.
REQ-025 If avm_readdatavalid=1 in the same cycle the request is accepted (waitrequest=0), that data SHALL be captured and the WAIT state skipped.
REQ-026 TS_REQ/TS_WAIT SHALL mirror REQ-023..025 with avm_address=1, capturing into ts_value and setting fail_ts on mismatch against EXPECTED_TS; then go to FINISH.
REQ-027 FINISH SHALL last one cycle: done=1, pass = NOT(fail_id OR fail_ts OR timeout), then return to IDLE.
REQ-028 An ID mismatch SHALL NOT abort the sequence; the timestamp read SHALL still occur.
REQ-029 A 16-bit wait counter SHALL clear on entry to each REQ state and increment each cycle spent in a REQ or WAIT state.
REQ-030 When the counter reaches TIMEOUT_CYCLES without a capture, the block SHALL set timeout, drop avm_read and go directly to FINISH; the remaining read is skipped and its value register keeps its reset/previous value.
REQ-031 avm_readdatavalid SHALL be ignored in IDLE, REQ (except REQ-025), and FINISH; stray data SHALL NOT alter results.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 avm_address SHALL be stable while avm_read=1 and avm_waitrequest=1.
REQ-034 Result flags and value registers SHALL hold until the next accepted start or reset.

Reset
REQ-035 During reset the state SHALL be IDLE; busy, done, pass, fail_id, fail_ts, timeout and avm_read SHALL be 0; avm_address 0; id_value and ts_value 32'd0; wait counter 0.
REQ-036 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse; the outstanding read data is discarded.

Verification
REQ-037 Zero-wait, one-cycle-latency slave returning 0 / 1617931578, pulse start -> two reads (address 0 then 1), done pulse, pass=1, id_value=0, ts_value=1617931578, total sequence 6 cycles start-to-done.
REQ-038 Slave returns 0x00000005 at address 0 -> fail_id=1, fail_ts=0, pass=0, timestamp read still issued.
REQ-039 waitrequest high 3 cycles on each read -> avm_read and avm_address held stable throughout; pass=1.
REQ-040 readdatavalid never asserted, TIMEOUT_CYCLES=8 -> timeout=1 at most 9 cycles after ID_REQ entry, done pulse, pass=0, no address-1 read issued.
REQ-041 Reset asserted during TS_WAIT -> all outputs at REQ-035 values next cycle, no done; a following start yields a normal pass.
REQ-042 start pulsed while busy and readdatavalid pulsed in IDLE -> no effect on sequence or results.
